game_timer_digits: RTL and testbench

//  Game-clock source for the colorizer stage. Counts play time down in BCD from START_SEC to 000 at 1 Hz.

---
 rtl/game_pkg.sv | 58 +++++
 rtl/digit_glyph_rom.sv | 37 +++
 rtl/game_timer_digits.sv | 172 +++++++++++++++++
 tb/tb_game_timer_digits.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - colour constants, state encoding and BCD helpers for the game timer
//
// Shared by game_timer_digits. Provides:
//   COLOR_TRANSPARENT / COLOR_BLACK / COLOR_RED  pixel colour codes
//   S_IDLE / S_RUN / S_PAUSED / S_EXPIRED         state encoding, wrapped by state_t
//   DIGIT_PX                                      on-screen digit size in pixels (8x8 glyph scaled x2)
//   sec_to_bcd()                                  decimal seconds to 3-digit BCD
//   bcd_dec()                                     3-digit BCD decrement with borrow chain, floors at 000

package game_pkg;

  localparam logic [7:0] COLOR_TRANSPARENT = 8'd255;
  localparam logic [7:0] COLOR_BLACK       = 8'd0;
  localparam logic [7:0] COLOR_RED         = 8'b11100000;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_RUN     = S_RUN,
    ST_PAUSED  = S_PAUSED,
    ST_EXPIRED = S_EXPIRED
  } state_t;

  localparam int DIGIT_PX = 16;

  function automatic logic [11:0] sec_to_bcd(input int s);
    return {4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = v[11:8];
    t = v[7:4];
    o = v[3:0];
    if (v == 12'h000) begin
      return 12'h000;
    end
    if (o != 4'd0) begin
      o = o - 4'd1;
    end else begin
      o = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, o};
  endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// rtl/digit_glyph_rom.sv - 8x8 glyph rows for BCD digits 0-9
//
// Combinational lookup.
//   bcd  in  4  digit code; 10-15 render blank (all zeros)
//   row  in  3  glyph row, 0 = top
//   bits out 8  glyph row pixels, bit 7 = leftmost column

module digit_glyph_rom (
  input  logic [3:0] bcd,
  input  logic [2:0] row,
  output logic [7:0] bits
);

  // Whole glyph as 64 bits, top row in the most significant byte.
  logic [63:0] glyph;

  always_comb begin
    glyph = 64'h0;
    case (bcd)
      4'd0:    glyph = 64'h3C666E7666663C00;
      4'd1:    glyph = 64'h1838181818187E00;
      4'd2:    glyph = 64'h3C66060C30607E00;
      4'd3:    glyph = 64'h3C66061C06663C00;
      4'd4:    glyph = 64'h0C1C3C6C7E0C0C00;
      4'd5:    glyph = 64'h7E607C0606663C00;
      4'd6:    glyph = 64'h3C607C6666663C00;
      4'd7:    glyph = 64'h7E060C1830303000;
      4'd8:    glyph = 64'h3C66663C66663C00;
      4'd9:    glyph = 64'h3C66663E060C3800;
      default: glyph = 64'h0;
    endcase
  end

  // Row r lives at bit offset (7-r)*8; ~row is 7-row for a 3-bit value.
  assign bits = glyph[{~row, 3'b000} +: 8];

endmodule

// File: rtl/game_timer_digits.sv
// rtl/game_timer_digits.sv - BCD countdown game clock with three rendered timer digits
//
// Counts START_SEC down to 000 at one step per CLK_HZ clocks and draws the three
// digits (hundreds at X0, tens at X0+16, ones at X0+32, rows Y0..Y0+15) as pixel colours.
// Optional feature macro: WARN_BLINK_EN (blink the digits during the last ten seconds).
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   start                          1-cycle pulse: reload START_SEC and run
//   pause                          level: freeze the count while high
//   pixel_row, pixel_column        current VGA position
//   timer_color_3rd/high/low       registered hundreds/tens/ones pixel colour (1 clk latency)
//   seconds_bcd                    remaining time {hundreds, tens, ones}
//   running, time_up               high in RUN / in EXPIRED

module game_timer_digits
  import game_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int START_SEC = 120,
  parameter int X0        = 560,
  parameter int Y0        = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pause,
  input  logic [9:0]  pixel_row,
  input  logic [9:0]  pixel_column,
  output logic [7:0]  timer_color_3rd,
  output logic [7:0]  timer_high_color,
  output logic [7:0]  timer_low_color,
  output logic [11:0] seconds_bcd,
  output logic        running,
  output logic        time_up
);

  localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [11:0]     START_BCD = sec_to_bcd(START_SEC);
  localparam logic [10:0]     Y_TOP     = 11'(Y0);
  localparam logic [10:0]     Y_BOT     = 11'(Y0 + DIGIT_PX);

  state_t        state;
  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap = (presc == PRESC_MAX);

  // ---------------------------------------------------------------------------
  // Countdown FSM. start overrides everything, including pause, in any state.
  // The prescaler advances in every RUN cycle, even the one in which pause is
  // seen, so a tick coinciding with pause is lost but the phase keeps moving.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      seconds_bcd <= START_BCD;
      presc       <= '0;
      running     <= 1'b0;
      time_up     <= 1'b0;
    end else if (start) begin
      state       <= ST_RUN;
      seconds_bcd <= START_BCD;
      presc       <= '0;
      running     <= 1'b1;
      time_up     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
        end
        ST_RUN: begin
          presc <= wrap ? '0 : presc + 1'b1;
          if (pause) begin
            state   <= ST_PAUSED;
            running <= 1'b0;
          end else if (wrap) begin
            if (seconds_bcd == 12'h001) begin
              seconds_bcd <= 12'h000;
              state       <= ST_EXPIRED;
              running     <= 1'b0;
              time_up     <= 1'b1;
            end else begin
              seconds_bcd <= bcd_dec(seconds_bcd);
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_EXPIRED: begin
          seconds_bcd <= 12'h000;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Foreground colour for lit glyph pixels.
  // ---------------------------------------------------------------------------
  logic [7:0] fg;

`ifdef WARN_BLINK_EN
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

  // BCD ordering matches numeric ordering, so <= 010 compares directly.
  always_comb begin
    fg = COLOR_RED;
    if (state != ST_EXPIRED && seconds_bcd <= 12'h010 && presc >= PRESC_HALF) begin
      fg = COLOR_TRANSPARENT;
    end
  end
`else
  assign fg = COLOR_RED;
`endif

  // ---------------------------------------------------------------------------
  // Render. Positions are widened to 11 bits so that columns left of a box
  // never wrap into it; only the low 4 bits of the offset are needed for the
  // glyph coordinates because the box is 16 pixels wide/high.
  // ---------------------------------------------------------------------------
  logic [10:0]      col_w;
  logic [10:0]      row_w;
  logic             row_in;
  logic [2:0]       grow;
  logic [2:0][7:0]  color_d;
  logic [2:0][7:0]  color_q;

  assign col_w  = {1'b0, pixel_column};
  assign row_w  = {1'b0, pixel_row};
  assign row_in = (row_w >= Y_TOP) && (row_w < Y_BOT);
  assign grow   = 3'((row_w[3:0] - Y_TOP[3:0]) >> 1);

  for (genvar d = 0; d < 3; d++) begin : g_digit
    localparam logic [10:0] X_L = 11'(X0 + DIGIT_PX * d);
    localparam logic [10:0] X_R = 11'(X0 + DIGIT_PX * (d + 1));

    logic [7:0] bits;
    logic [2:0] gcol;
    logic       in_box;
    logic       pix_on;

    digit_glyph_rom u_rom (
      .bcd  (seconds_bcd[11-4*d -: 4]),
      .row  (grow),
      .bits (bits)
    );

    assign in_box     = (col_w >= X_L) && (col_w < X_R) && row_in;
    assign gcol       = 3'((col_w[3:0] - X_L[3:0]) >> 1);
    assign pix_on     = bits[3'd7 - gcol];
    assign color_d[d] = in_box ? (pix_on ? fg : COLOR_BLACK) : COLOR_TRANSPARENT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      color_q <= {3{COLOR_TRANSPARENT}};
    end else begin
      color_q <= color_d;
    end
  end

  assign timer_color_3rd  = color_q[0];
  assign timer_high_color = color_q[1];
  assign timer_low_color  = color_q[2];

endmodule

// File: tb/tb_game_timer_digits.sv
// tb/tb_game_timer_digits.sv - scoreboard bench for game_timer_digits

module tb_game_timer_digits;

  localparam int CLK_HZ    = 10;
  localparam int START_SEC = 120;
  localparam int X0        = 560;
  localparam int Y0        = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [9:0]  pixel_row = '0;
  logic [9:0]  pixel_column = '0;
  logic [7:0]  timer_color_3rd;
  logic [7:0]  timer_high_color;
  logic [7:0]  timer_low_color;
  logic [11:0] seconds_bcd;
  logic        running;
  logic        time_up;

  always #5 clk = ~clk;

  game_timer_digits #(
    .CLK_HZ    (CLK_HZ),
    .START_SEC (START_SEC),
    .X0        (X0),
    .Y0        (Y0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .pause            (pause),
    .pixel_row        (pixel_row),
    .pixel_column     (pixel_column),
    .timer_color_3rd  (timer_color_3rd),
    .timer_high_color (timer_high_color),
    .timer_low_color  (timer_low_color),
    .seconds_bcd      (seconds_bcd),
    .running          (running),
    .time_up          (time_up)
  );

  typedef struct {
    int sec;
    int run;
    int tup;
    int c0;
    int c1;
    int c2;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: remaining seconds as a plain integer, a mode number
  // (0 idle, 1 run, 2 paused, 3 expired) and the number of counted clocks
  // since the last second boundary.
  int m_sec = START_SEC;
  int m_ph  = 0;
  int m_st  = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] glyph(input int d, input int r);
    logic [63:0] g;
    case (d)
      0: g = 64'h3C666E7666663C00;
      1: g = 64'h1838181818187E00;
      2: g = 64'h3C66060C30607E00;
      3: g = 64'h3C66061C06663C00;
      4: g = 64'h0C1C3C6C7E0C0C00;
      5: g = 64'h7E607C0606663C00;
      6: g = 64'h3C607C6666663C00;
      7: g = 64'h7E060C1830303000;
      8: g = 64'h3C66663C66663C00;
      9: g = 64'h3C66663E060C3800;
      default: g = 64'h0;
    endcase
    return g[63-8*r -: 8];
  endfunction

  function automatic int to_bcd(input int s);
    return ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + (s % 10);
  endfunction

  function automatic int model_fg();
`ifdef WARN_BLINK_EN
    if (m_st == 3) return 224;
    if (m_sec <= 10 && m_ph >= CLK_HZ / 2) return 255;
    return 224;
`else
    return 224;
`endif
  endfunction

  function automatic int model_color(input int d, input int row, input int col);
    int x;
    int dig;
    logic [7:0] g;
    x = X0 + 16 * d;
    if (col >= x && col < x + 16 && row >= Y0 && row < Y0 + 16) begin
      dig = (d == 0) ? m_sec / 100 : (d == 1) ? (m_sec / 10) % 10 : m_sec % 10;
      g = glyph(dig, (row - Y0) / 2);
      return g[7 - (col - x) / 2] ? model_fg() : 0;
    end
    return 255;
  endfunction

  // One clock of stimulus: drive at the falling edge, queue what the DUT must
  // show after the following rising edge, then advance the model.
  task automatic step(input logic s, input logic p, input logic rn, input int row, input int col);
    exp_t e;
    @(negedge clk);
    start        = s;
    pause        = p;
    reset_n      = rn;
    pixel_row    = row[9:0];
    pixel_column = col[9:0];
    if (!rn) begin
      m_sec = START_SEC;
      m_ph  = 0;
      m_st  = 0;
      e.c0 = 255; e.c1 = 255; e.c2 = 255;
    end else begin
      e.c0 = model_color(0, row, col);
      e.c1 = model_color(1, row, col);
      e.c2 = model_color(2, row, col);
      if (s) begin
        m_sec = START_SEC;
        m_ph  = 0;
        m_st  = 1;
      end else if (m_st == 1) begin
        m_ph = m_ph + 1;
        if (m_ph == CLK_HZ) begin
          m_ph = 0;
          if (!p) begin
            m_sec = m_sec - 1;
            if (m_sec == 0) m_st = 3;
          end
        end
        if (p) m_st = 2;
      end else if (m_st == 2) begin
        if (!p) m_st = 1;
      end
    end
    e.sec = to_bcd(m_sec);
    e.run = (m_st == 1) ? 1 : 0;
    e.tup = (m_st == 3) ? 1 : 0;
    q.push_back(e);
  endtask

  int px_row;
  int px_col;

  task automatic rand_px();
    if ($urandom_range(0, 9) < 8) begin
      px_row = Y0 - 2 + int'($urandom_range(0, 19));
      px_col = X0 - 4 + int'($urandom_range(0, 55));
    end else begin
      px_row = int'($urandom_range(0, 1023));
      px_col = int'($urandom_range(0, 1023));
    end
  endtask

  task automatic run_steps(input int n, input logic p);
    for (int i = 0; i < n; i++) begin
      rand_px();
      step(1'b0, p, 1'b1, px_row, px_col);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the DUT presents a fresh result after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("seconds_bcd", int'(seconds_bcd), e.sec);
        check("running", int'(running), e.run);
        check("time_up", int'(time_up), e.tup);
        check("timer_color_3rd", int'(timer_color_3rd), e.c0);
        check("timer_high_color", int'(timer_high_color), e.c1);
        check("timer_low_color", int'(timer_low_color), e.c2);
      end
    end
  end

  initial begin
    logic p;
    int   guard;

    for (int i = 0; i < 3; i++) begin
      rand_px();
      step(1'b0, 1'b0, 1'b0, px_row, px_col);
    end
    settle();
    check("reset_seconds", int'(seconds_bcd), 'h120);
    check("reset_running", int'(running), 0);
    check("reset_time_up", int'(time_up), 0);
    check("reset_color_low", int'(timer_low_color), 255);

    rand_px();
    step(1'b1, 1'b0, 1'b1, px_row, px_col);
    run_steps(10, 1'b0);
    settle();
    check("first_tick", int'(seconds_bcd), 'h119);
    check("first_tick_running", int'(running), 1);

    run_steps(200, 1'b0);
    settle();
    check("borrow_hundreds", int'(seconds_bcd), 'h099);

    run_steps(5, 1'b0);
    run_steps(35, 1'b1);
    settle();
    check("pause_hold", int'(seconds_bcd), 'h099);
    check("pause_running", int'(running), 0);
    run_steps(4, 1'b0);
    settle();
    check("resume_before_tick", int'(seconds_bcd), 'h099);
    run_steps(1, 1'b0);
    settle();
    check("resume_tick", int'(seconds_bcd), 'h098);

    // Random pauses until the count expires.
    p = 1'b0;
    guard = 0;
    while (m_st != 3 && guard < 6000) begin
      if ($urandom_range(0, 9) == 0) p = ~p;
      rand_px();
      step(1'b0, p, 1'b1, px_row, px_col);
      guard++;
    end
    settle();
    check("expired_time_up", int'(time_up), 1);
    check("expired_running", int'(running), 0);
    run_steps(20, 1'b0);
    settle();
    check("expired_hold", int'(seconds_bcd), 'h000);

    step(1'b1, 1'b0, 1'b1, Y0 + 2, X0 + 2);
    settle();
    check("restart_seconds", int'(seconds_bcd), 'h120);
    check("restart_running", int'(running), 1);
    step(1'b0, 1'b0, 1'b1, Y0 + 2, X0 + 2);
    settle();
    check("px_hund_off", int'(timer_color_3rd), 0);
    check("px_hund_other", int'(timer_high_color), 255);
    step(1'b0, 1'b0, 1'b1, Y0 + 2, X0 + 6);
    settle();
    check("px_hund_on", int'(timer_color_3rd), 224);
    step(1'b0, 1'b0, 1'b1, Y0, X0 + 40);
    settle();
    check("px_ones_on", int'(timer_low_color), 224);
    check("px_ones_other", int'(timer_color_3rd), 255);
    step(1'b0, 1'b0, 1'b1, Y0, X0 - 1);
    settle();
    check("px_left_3rd", int'(timer_color_3rd), 255);
    check("px_left_high", int'(timer_high_color), 255);
    check("px_left_low", int'(timer_low_color), 255);

    // Asynchronous reset mid-count, then start together with pause.
    run_steps(15, 1'b0);
    rand_px();
    step(1'b0, 1'b0, 1'b0, px_row, px_col);
    #1;
    check("async_reset_seconds", int'(seconds_bcd), 'h120);
    check("async_reset_running", int'(running), 0);
    rand_px();
    step(1'b1, 1'b1, 1'b1, px_row, px_col);
    settle();
    check("start_beats_pause", int'(running), 1);

    p = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) p = ~p;
      rand_px();
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, p, 1'b1, px_row, px_col);
    end

    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
